// File: rtl/ddr_reg_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_reg_axi_pkg
//  Description : Shared constants, state encodings and helpers for the
//                register-bus AXI4 responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_reg_axi_pkg;

    localparam int ADDR_W = 15;
    localparam int ID_W   = 6;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Only 4-byte beats with FIXED or INCR bursts are served.
    function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || burst[1];
    endfunction

    // Replace the strobed bytes of old_word with those of new_word.
    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_reg_axi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_reg_axi_responder_if
//  Description : Five-channel AXI4 register bus (15-bit address, 32-bit data,
//                6-bit ID) with initiator and responder views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr_reg_axi_responder_if;
    import ddr_reg_axi_pkg::*;

    logic              regAWVALID;
    logic              regAWREADY;
    logic [ADDR_W-1:0] regAWADDR;
    logic [ID_W-1:0]   regAWID;
    logic [LEN_W-1:0]  regAWLEN;
    logic [2:0]        regAWSIZE;
    logic [1:0]        regAWBURST;

    logic              regWVALID;
    logic              regWREADY;
    logic [DATA_W-1:0] regWDATA;
    logic [STRB_W-1:0] regWSTRB;
    logic              regWLAST;

    logic              regBVALID;
    logic              regBREADY;
    logic [ID_W-1:0]   regBID;
    logic [1:0]        regBRESP;

    logic              regARVALID;
    logic              regARREADY;
    logic [ADDR_W-1:0] regARADDR;
    logic [ID_W-1:0]   regARID;
    logic [LEN_W-1:0]  regARLEN;
    logic [2:0]        regARSIZE;
    logic [1:0]        regARBURST;

    logic              regRVALID;
    logic              regRREADY;
    logic [DATA_W-1:0] regRDATA;
    logic [ID_W-1:0]   regRID;
    logic [1:0]        regRRESP;
    logic              regRLAST;

    modport slave (
        input  regAWVALID, regAWADDR, regAWID, regAWLEN, regAWSIZE, regAWBURST,
        output regAWREADY,
        input  regWVALID, regWDATA, regWSTRB, regWLAST,
        output regWREADY,
        output regBVALID, regBID, regBRESP,
        input  regBREADY,
        input  regARVALID, regARADDR, regARID, regARLEN, regARSIZE, regARBURST,
        output regARREADY,
        output regRVALID, regRDATA, regRID, regRRESP, regRLAST,
        input  regRREADY
    );

    modport master (
        output regAWVALID, regAWADDR, regAWID, regAWLEN, regAWSIZE, regAWBURST,
        input  regAWREADY,
        output regWVALID, regWDATA, regWSTRB, regWLAST,
        input  regWREADY,
        input  regBVALID, regBID, regBRESP,
        output regBREADY,
        output regARVALID, regARADDR, regARID, regARLEN, regARSIZE, regARBURST,
        input  regARREADY,
        input  regRVALID, regRDATA, regRID, regRRESP, regRLAST,
        output regRREADY
    );

endinterface
`default_nettype wire

// File: rtl/ddr_reg_axi_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_reg_axi_burst_addr
//  Description : Per-channel burst address and beat counter. With LOOKAHEAD=0
//                the outputs describe the current beat; with LOOKAHEAD=1 they
//                describe the beat that will be current after this edge, so a
//                registered data path can be loaded in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_reg_axi_burst_addr
    import ddr_reg_axi_pkg::*;
#(
    parameter bit LOOKAHEAD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    input  logic [1:0]        start_burst,
    input  logic              step,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_burst;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [1:0]        w_burst_nxt;

    // Next pointer: reload on start, otherwise advance one beat on step.
    always_comb begin
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_burst_nxt = r_burst;
        if (start) begin
            w_addr_nxt  = start_addr;
            w_cnt_nxt   = '0;
            w_len_nxt   = start_len;
            w_burst_nxt = start_burst;
        end else if (step) begin
            w_cnt_nxt = r_cnt + LEN_W'(1);
            // INCR wraps naturally at 2^15; FIXED and illegal types hold.
            if (r_burst == BURST_INCR) begin
                w_addr_nxt = r_addr + ADDR_W'(4);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_burst <= BURST_FIXED;
        end else begin
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    assign addr_out = LOOKAHEAD ? w_addr_nxt : r_addr;
    assign last     = LOOKAHEAD ? (w_cnt_nxt == w_len_nxt) : (r_cnt == r_len);

endmodule
`default_nettype wire

// File: rtl/ddr_reg_axi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_reg_axi_responder
//  Description : AXI4 responder backed by a flop register bank. Word 0 holds
//                a read-only ID; independent write and read state machines
//                serve FIXED/INCR bursts of up to 256 beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_reg_axi_responder
    import ddr_reg_axi_pkg::*;
#(
    parameter int          NUM_REGS = 64,
    parameter logic [31:0] ID_VALUE = 32'h5449_0375,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    regACLK,
    input  logic                    reg_rst,
    ddr_reg_axi_responder_if.slave  bus
);

    localparam int          c_idx_w    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [15:0] c_addr_lim = 16'(4 * NUM_REGS);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // ------------------------------------------------------------------ write
    w_state_t          r_wstate;
    w_state_t          w_wstate_nxt;
    logic              w_awready;
    logic              w_wready;
    logic              w_bvalid;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic [ID_W-1:0]   r_wid;
    logic              r_werr;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_wlast_beat;
    logic              w_win_range;
    logic              w_wen;

    assign w_aw_hs = bus.regAWVALID && w_awready;
    assign w_w_hs  = bus.regWVALID && w_wready;

    ddr_reg_axi_burst_addr #(.LOOKAHEAD(1'b0)) u_wr_addr (
        .clk         (regACLK),
        .rst         (reg_rst),
        .start       (w_aw_hs),
        .start_addr  (bus.regAWADDR),
        .start_len   (bus.regAWLEN),
        .start_burst (bus.regAWBURST),
        .step        (w_w_hs),
        .addr_out    (w_waddr),
        .last        (w_wlast_beat)
    );

    // addr < 4*NUM_REGS is the same test as addr[14:2] < NUM_REGS.
    assign w_win_range = ({1'b0, w_waddr} < c_addr_lim);
    assign w_wen       = w_w_hs && w_win_range && (w_waddr[ADDR_W-1:2] != '0) && !r_werr;

    // Write state register.
    always_ff @(posedge regACLK) begin
        if (reg_rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Write next-state and channel ready/valid decode.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (bus.regAWVALID) begin
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                w_wready = 1'b1;
                // The beat counter, not WLAST, decides where the burst ends.
                if (bus.regWVALID && w_wlast_beat) begin
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (bus.regBREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Latch write ID and accumulate the sticky error for the whole burst.
    always_ff @(posedge regACLK) begin
        if (reg_rst) begin
            r_wid  <= '0;
            r_werr <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid  <= bus.regAWID;
            r_werr <= cfg_err(bus.regAWSIZE, bus.regAWBURST);
        end else if (w_w_hs) begin
            r_werr <= r_werr || !w_win_range || (bus.regWLAST != w_wlast_beat);
        end
    end

    // Register bank: word 0 is reloaded with the ID and never written.
    always_ff @(posedge regACLK) begin
        if (reg_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else if (w_wen) begin
            r_mem[w_waddr[2 +: c_idx_w]] <= strb_merge(r_mem[w_waddr[2 +: c_idx_w]],
                                                       bus.regWDATA, bus.regWSTRB);
        end
    end

    assign bus.regAWREADY = w_awready;
    assign bus.regWREADY  = w_wready;
    assign bus.regBVALID  = w_bvalid;
    assign bus.regBID     = r_wid;
    assign bus.regBRESP   = r_werr ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------- read
    r_state_t          r_rstate;
    r_state_t          w_rstate_nxt;
    logic              w_arready;
    logic              w_rvalid;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_r_load;
    logic [ID_W-1:0]   r_rid;
    logic              r_rcfg_err;
    logic              w_rcfg_err_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic [ADDR_W-1:0] w_raddr_nxt;
    logic              w_rlast_nxt;
    logic              w_rbeat_err;

    assign w_ar_hs  = bus.regARVALID && w_arready;
    assign w_r_hs   = bus.regRREADY && w_rvalid;
    // Load the output registers on AR accept and on every non-final R accept.
    assign w_r_load = w_ar_hs || (w_r_hs && !r_rlast);

    ddr_reg_axi_burst_addr #(.LOOKAHEAD(1'b1)) u_rd_addr (
        .clk         (regACLK),
        .rst         (reg_rst),
        .start       (w_ar_hs),
        .start_addr  (bus.regARADDR),
        .start_len   (bus.regARLEN),
        .start_burst (bus.regARBURST),
        .step        (w_r_hs && !r_rlast),
        .addr_out    (w_raddr_nxt),
        .last        (w_rlast_nxt)
    );

    assign w_rcfg_err_nxt = w_ar_hs ? cfg_err(bus.regARSIZE, bus.regARBURST) : r_rcfg_err;
    assign w_rbeat_err    = w_rcfg_err_nxt || !({1'b0, w_raddr_nxt} < c_addr_lim);

    // Read state register.
    always_ff @(posedge regACLK) begin
        if (reg_rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read next-state and channel ready/valid decode.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (bus.regARVALID) begin
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (bus.regRREADY && r_rlast) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Registered read beat; the bank is sampled before any same-cycle write.
    always_ff @(posedge regACLK) begin
        if (reg_rst) begin
            r_rid      <= '0;
            r_rcfg_err <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rlast    <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rid      <= bus.regARID;
                r_rcfg_err <= w_rcfg_err_nxt;
            end
            if (w_r_load) begin
                r_rdata <= w_rbeat_err ? ERR_DATA : r_mem[w_raddr_nxt[2 +: c_idx_w]];
                r_rresp <= w_rbeat_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast <= w_rlast_nxt;
            end
        end
    end

    assign bus.regARREADY = w_arready;
    assign bus.regRVALID  = w_rvalid;
    assign bus.regRDATA   = r_rdata;
    assign bus.regRID     = r_rid;
    assign bus.regRRESP   = r_rresp;
    assign bus.regRLAST   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_ddr_reg_axi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_reg_axi_responder
//  Description : Directed self-checking bench for ddr_reg_axi_responder:
//                a table of single-beat transactions plus burst, backpressure,
//                concurrency and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_reg_axi_responder;
    import ddr_reg_axi_pkg::*;

    localparam int          NREGS = 64;
    localparam logic [31:0] IDV   = 32'h5449_0375;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_reg_axi_responder_if bus ();

    ddr_reg_axi_responder #(
        .NUM_REGS (NREGS),
        .ID_VALUE (IDV),
        .ERR_DATA (ERRD)
    ) dut (
        .regACLK (clk),
        .reg_rst (rst),
        .bus     (bus)
    );

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [5:0]  id;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vt [NVEC];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NREGS];

    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [5:0]  rd_id   [256];
    int          rd_n;
    int          rd_vcyc;
    logic        rd_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = (i == 0) ? IDV : 32'h0;
    endtask

    task automatic do_write(input logic [14:0] addr, input logic [5:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                            input logic [3:0] strb, input int wlast_at, input int bdelay,
                            output logic [1:0] resp, output logic [5:0] bid);
        int t;
        int hold;
        bus.regAWVALID = 1'b1; bus.regAWADDR = addr; bus.regAWID = id; bus.regAWLEN = len;
        bus.regAWSIZE = size; bus.regAWBURST = burst;
        t = 0;
        while (!bus.regAWREADY && t < 200) begin tick(); t++; end
        check("aw_ready_seen", bus.regAWREADY, 1);
        tick();
        bus.regAWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.regWVALID = 1'b1; bus.regWDATA = base + 32'(i); bus.regWSTRB = strb;
            bus.regWLAST = (i == wlast_at);
            t = 0;
            while (!bus.regWREADY && t < 200) begin tick(); t++; end
            tick();
        end
        bus.regWVALID = 1'b0; bus.regWLAST = 1'b0;
        t = 0;
        while (!bus.regBVALID && t < 200) begin tick(); t++; end
        check("b_valid_seen", bus.regBVALID, 1);
        if (bdelay > 0) begin
            hold = 0;
            for (int k = 0; k < bdelay; k++) begin
                if (bus.regBVALID) hold++;
                tick();
            end
            check("b_valid_held", hold, bdelay);
        end
        resp = bus.regBRESP;
        bid  = bus.regBID;
        bus.regBREADY = 1'b1;
        tick();
        bus.regBREADY = 1'b0;
        check("aw_ready_after_b", bus.regAWREADY, 1);
    endtask

    // mode 0: RREADY always high; mode 1: RREADY pattern 1,0,0 repeating.
    task automatic do_read(input logic [14:0] addr, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int          t;
        int          cyc;
        logic        rdy;
        logic        stall;
        logic        done;
        logic [31:0] p_data;
        logic [8:0]  p_ctl;
        bus.regARVALID = 1'b1; bus.regARADDR = addr; bus.regARID = id; bus.regARLEN = len;
        bus.regARSIZE = size; bus.regARBURST = burst;
        t = 0;
        while (!bus.regARREADY && t < 200) begin tick(); t++; end
        check("ar_ready_seen", bus.regARREADY, 1);
        tick();
        bus.regARVALID = 1'b0;
        rd_first = bus.regRVALID;
        rd_n = 0; rd_vcyc = 0; stall = 1'b0; done = 1'b0; cyc = 0;
        p_data = '0; p_ctl = '0;
        while (!done && cyc < 2000) begin
            rdy = (mode == 0) || (cyc % 3 == 0);
            bus.regRREADY = rdy;
            if (bus.regRVALID) begin
                if (stall) begin
                    check("r_stall_data", bus.regRDATA, p_data);
                    check("r_stall_ctl", {bus.regRRESP, bus.regRLAST, bus.regRID}, p_ctl);
                end
                rd_vcyc++;
                if (rdy) begin
                    if (rd_n < 256) begin
                        rd_data[rd_n] = bus.regRDATA; rd_resp[rd_n] = bus.regRRESP;
                        rd_last[rd_n] = bus.regRLAST; rd_id[rd_n] = bus.regRID;
                    end
                    rd_n++;
                    done = bus.regRLAST;
                end
                stall  = !rdy;
                p_data = bus.regRDATA;
                p_ctl  = {bus.regRRESP, bus.regRLAST, bus.regRID};
            end else begin
                stall = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.regRREADY = 1'b0;
        check("r_burst_done", done, 1);
    endtask

    task automatic verify_burst(input string tag, input int start, input int n, input logic [5:0] id);
        check($sformatf("%s_nbeats", tag), rd_n, n);
        for (int i = 0; i < n && i < rd_n; i++) begin
            check($sformatf("%s_data%0d", tag, i), rd_data[i], model[start + i]);
            check($sformatf("%s_resp%0d", tag, i), rd_resp[i], RESP_OKAY);
            check($sformatf("%s_last%0d", tag, i), rd_last[i], (i == n - 1));
            check($sformatf("%s_id%0d", tag, i), rd_id[i], id);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp;
        logic [5:0] bid;
        int         idx;

        bus.regAWVALID = 0; bus.regAWADDR = 0; bus.regAWID = 0; bus.regAWLEN = 0;
        bus.regAWSIZE = SIZE_4B; bus.regAWBURST = BURST_INCR;
        bus.regWVALID = 0; bus.regWDATA = 0; bus.regWSTRB = 0; bus.regWLAST = 0;
        bus.regBREADY = 0;
        bus.regARVALID = 0; bus.regARADDR = 0; bus.regARID = 0; bus.regARLEN = 0;
        bus.regARSIZE = SIZE_4B; bus.regARBURST = BURST_INCR;
        bus.regRREADY = 0;

        //        wr    addr      id     size    burst  data           strb   resp   rdata
        vt[0]  = '{1'b1, 15'h0010, 6'h01, 3'b010, 2'b01, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vt[1]  = '{1'b0, 15'h0010, 6'h02, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
        vt[2]  = '{1'b1, 15'h0010, 6'h03, 3'b010, 2'b01, 32'hFFFF_FFFF, 4'h5, 2'b00, 32'h0};
        vt[3]  = '{1'b0, 15'h0010, 6'h04, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h12FF_56FF};
        vt[4]  = '{1'b1, 15'h0000, 6'h05, 3'b010, 2'b01, 32'h0000_0000, 4'hF, 2'b00, 32'h0};
        vt[5]  = '{1'b0, 15'h0000, 6'h06, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h5449_0375};
        vt[6]  = '{1'b0, 15'h0100, 6'h07, 3'b010, 2'b01, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF};
        vt[7]  = '{1'b1, 15'h0100, 6'h08, 3'b010, 2'b01, 32'h0000_0001, 4'hF, 2'b10, 32'h0};
        vt[8]  = '{1'b1, 15'h0014, 6'h09, 3'b011, 2'b01, 32'h0000_0077, 4'hF, 2'b10, 32'h0};
        vt[9]  = '{1'b0, 15'h0014, 6'h0A, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h0};
        vt[10] = '{1'b1, 15'h00FC, 6'h0B, 3'b010, 2'b00, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vt[11] = '{1'b0, 15'h00FE, 6'h0C, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vt[12] = '{1'b0, 15'h0010, 6'h0D, 3'b010, 2'b10, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF};
        vt[13] = '{1'b1, 15'h0018, 6'h0E, 3'b010, 2'b11, 32'h0000_AAAA, 4'hF, 2'b10, 32'h0};
        vt[14] = '{1'b0, 15'h0018, 6'h0F, 3'b001, 2'b01, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF};
        vt[15] = '{1'b0, 15'h7FFC, 6'h10, 3'b010, 2'b01, 32'h0,         4'h0, 2'b10, 32'hDEAD_BEEF};

        model_reset();

        // Reset state, checked while reset is held and right after release.
        tick(); tick();
        check("rst_awready", bus.regAWREADY, 1);
        check("rst_arready", bus.regARREADY, 1);
        check("rst_valids", {bus.regWREADY, bus.regBVALID, bus.regRVALID}, 3'b000);
        check("rst_rdata", bus.regRDATA, 32'h0);
        check("rst_ids_resp", {bus.regRID, bus.regBID, bus.regRRESP, bus.regBRESP, bus.regRLAST}, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {bus.regAWREADY, bus.regARREADY}, 2'b11);
        check("post_rst_valid", {bus.regBVALID, bus.regRVALID}, 2'b00);

        // Single-beat vector table.
        for (int i = 0; i < NVEC; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].id, 8'd0, vt[i].size, vt[i].burst, vt[i].data,
                         vt[i].strb, 0, 0, resp, bid);
                check($sformatf("v%0d_bresp", i), resp, vt[i].exp_resp);
                check($sformatf("v%0d_bid", i), bid, vt[i].id);
                idx = int'(vt[i].addr[14:2]);
                if (vt[i].exp_resp == RESP_OKAY && idx != 0 && idx < NREGS)
                    model[idx] = merge(model[idx], vt[i].data, vt[i].strb);
            end else begin
                do_read(vt[i].addr, vt[i].id, 8'd0, vt[i].size, vt[i].burst, 0);
                check($sformatf("v%0d_rvalid_next", i), rd_first, 1);
                check($sformatf("v%0d_nbeats", i), rd_n, 1);
                check($sformatf("v%0d_rresp", i), rd_resp[0], vt[i].exp_resp);
                check($sformatf("v%0d_rdata", i), rd_data[0], vt[i].exp_data);
                check($sformatf("v%0d_rlast", i), rd_last[0], 1);
                check($sformatf("v%0d_rid", i), rd_id[0], vt[i].id);
            end
        end

        // 4-beat INCR write then back-to-back read with RREADY held high.
        do_write(15'h0020, 6'h15, 8'd3, SIZE_4B, BURST_INCR, 32'hA0, 4'hF, 3, 0, resp, bid);
        check("incr_bresp", resp, RESP_OKAY);
        check("incr_bid", bid, 6'h15);
        for (int i = 0; i < 4; i++) model[8 + i] = 32'hA0 + 32'(i);
        do_read(15'h0020, 6'h2A, 8'd3, SIZE_4B, BURST_INCR, 0);
        check("incr_rvalid_next", rd_first, 1);
        check("incr_valid_cycles", rd_vcyc, 4);
        verify_burst("incr_rd", 8, 4, 6'h2A);

        // 8-beat read under RREADY backpressure, then delayed BREADY.
        do_read(15'h0020, 6'h07, 8'd7, SIZE_4B, BURST_INCR, 1);
        verify_burst("bp_rd", 8, 8, 6'h07);
        do_write(15'h0040, 6'h01, 8'd0, SIZE_4B, BURST_INCR, 32'h1111_1111, 4'hF, 0, 5, resp, bid);
        check("bp_bresp", resp, RESP_OKAY);
        model[16] = 32'h1111_1111;

        // Write beat and read address accepted in the same cycle on word 16.
        bus.regAWVALID = 1'b1; bus.regAWADDR = 15'h0040; bus.regAWID = 6'h22; bus.regAWLEN = 8'd0;
        bus.regAWSIZE = SIZE_4B; bus.regAWBURST = BURST_INCR;
        check("conc_awready", bus.regAWREADY, 1);
        tick();
        bus.regAWVALID = 1'b0;
        bus.regWVALID = 1'b1; bus.regWDATA = 32'h2222_2222; bus.regWSTRB = 4'hF; bus.regWLAST = 1'b1;
        bus.regARVALID = 1'b1; bus.regARADDR = 15'h0040; bus.regARID = 6'h33; bus.regARLEN = 8'd0;
        bus.regARSIZE = SIZE_4B; bus.regARBURST = BURST_INCR;
        check("conc_ready_pair", {bus.regWREADY, bus.regARREADY}, 2'b11);
        tick();
        bus.regWVALID = 1'b0; bus.regWLAST = 1'b0; bus.regARVALID = 1'b0;
        check("conc_rvalid", bus.regRVALID, 1);
        check("conc_old_data", bus.regRDATA, 32'h1111_1111);
        check("conc_bvalid", bus.regBVALID, 1);
        check("conc_bresp", {bus.regBID, bus.regBRESP}, {6'h22, RESP_OKAY});
        bus.regRREADY = 1'b1; bus.regBREADY = 1'b1;
        tick();
        bus.regRREADY = 1'b0; bus.regBREADY = 1'b0;
        model[16] = 32'h2222_2222;
        do_read(15'h0040, 6'h34, 8'd0, SIZE_4B, BURST_INCR, 0);
        verify_burst("conc_new", 16, 1, 6'h34);

        // Whole bank: confirms that the erroring writes changed nothing.
        do_read(15'h0000, 6'h3F, 8'(NREGS - 1), SIZE_4B, BURST_INCR, 0);
        verify_burst("bank", 0, NREGS, 6'h3F);

        // WLAST asserted on beat 1 of a 4-beat burst.
        do_write(15'h0030, 6'h05, 8'd3, SIZE_4B, BURST_INCR, 32'hB0, 4'hF, 1, 0, resp, bid);
        check("early_wlast_bresp", resp, RESP_SLVERR);
        check("early_wlast_bid", bid, 6'h05);

        // Reset in the middle of a stalled read burst.
        bus.regARVALID = 1'b1; bus.regARADDR = 15'h0020; bus.regARID = 6'h09; bus.regARLEN = 8'd7;
        bus.regARSIZE = SIZE_4B; bus.regARBURST = BURST_INCR;
        check("mid_arready", bus.regARREADY, 1);
        tick();
        bus.regARVALID = 1'b0;
        tick();
        check("mid_rvalid_before", bus.regRVALID, 1);
        rst = 1'b1;
        tick();
        check("mid_rvalid_after", bus.regRVALID, 0);
        check("mid_ready_after", {bus.regARREADY, bus.regAWREADY}, 2'b11);
        rst = 1'b0;
        tick();
        model_reset();
        do_read(15'h0000, 6'h01, 8'(NREGS - 1), SIZE_4B, BURST_INCR, 0);
        verify_burst("rst_bank", 0, NREGS, 6'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
